uart_rx_os: RTL



---
 rtl/uart_rx_os_if.sv | 24 ++
 rtl/uart_rx_os.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os_if.sv
// FIFO write port between the oversampling UART receiver and its downstream FIFO.
// The master side drives the write strobe and data; the slave side reports full.
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic                 wr_clk;
    logic                 wr_en;
    logic [DATA_BITS-1:0] dout;
    logic                 full;

    modport master (
        output wr_clk,
        output wr_en,
        output dout,
        input  full
    );

    modport slave (
        input  wr_clk,
        input  wr_en,
        input  dout,
        output full
    );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote and FIFO write port.
// Define UART_RX_PARITY_EN to compile in the parity bit, PARITY state and parity_err.
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic         clk_rx,
    input  logic         rst,
    input  logic         rx,
    uart_rx_os_if.master wr,
    output logic         frame_err,
    output logic         parity_err,
    output logic         overrun,
    output logic         busy
);
    localparam int H  = OVERSAMPLE / 2;
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    if (DATA_BITS < 5 || DATA_BITS > 9 ||
        OVERSAMPLE < 8 || OVERSAMPLE > 64 || (OVERSAMPLE % 2) != 0 ||
        STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_rx_os: illegal parameter set");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;
`endif

    state_t               state;
    logic                 s1;
    logic                 s2;
    logic                 s1_real;
    logic                 armed;
    logic                 start_q;
    logic [CW-1:0]        cnt;
    logic                 v0;
    logic                 v1;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 stop_bad;
    logic [DATA_BITS-1:0] sh;
    logic [DATA_BITS-1:0] dout_q;
    logic                 wr_en_q;
    logic                 fe_q;
    logic                 ov_q;
    logic                 busy_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
    logic                 pe_q;
`endif

    logic at_s0;
    logic at_s1;
    logic at_vote;
    logic at_wrap;
    logic vote;
    logic last_stop;

    assign at_s0     = cnt == CW'(H - 1);
    assign at_s1     = cnt == CW'(H);
    assign at_vote   = cnt == CW'(H + 1);
    assign at_wrap   = cnt == CW'(OVERSAMPLE - 1);
    assign vote      = (v0 & v1) | (v0 & s2) | (v1 & s2);
    assign last_stop = (STOP_BITS == 1) || stop_idx;

    // armed blocks a start until a real high sample has passed stage 1,
    // so rx held low across reset release is not taken as a start edge.
    always_ff @(posedge clk_rx) begin
        if (rst) begin
            s1      <= 1'b1;
            s2      <= 1'b1;
            s1_real <= 1'b0;
            armed   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            s1      <= rx;
            s2      <= s1;
            s1_real <= 1'b1;
            armed   <= armed | (s1 & s1_real);
            start_q <= armed & s2 & ~s1;
        end
    end

    always_ff @(posedge clk_rx) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            v0       <= 1'b1;
            v1       <= 1'b1;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            stop_bad <= 1'b0;
            sh       <= '0;
            dout_q   <= '0;
            wr_en_q  <= 1'b0;
            fe_q     <= 1'b0;
            ov_q     <= 1'b0;
            busy_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad  <= 1'b0;
            pe_q     <= 1'b0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_q    <= 1'b0;
`endif
            if (state == S_IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= at_wrap ? '0 : cnt + CW'(1);
            end
            if (at_s0) begin
                v0 <= s2;
            end
            if (at_s1) begin
                v1 <= s2;
            end

            unique case (state)
                S_IDLE: begin
                    if (start_q) begin
                        state  <= S_START;
                        busy_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (at_vote && vote) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else if (at_wrap) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (at_vote) begin
                        sh <= {vote, sh[DATA_BITS-1:1]};
                    end
                    if (at_wrap) begin
                        if (bit_idx == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                            stop_idx <= 1'b0;
                            stop_bad <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (at_vote) begin
                        par_bad <= vote ^ (^sh) ^ 1'(PARITY_ODD);
                    end
                    if (at_wrap) begin
                        state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (at_vote) begin
                        if (last_stop) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                            if (!vote || stop_bad) begin
                                fe_q <= 1'b1;
                            end else begin
`ifdef UART_RX_PARITY_EN
                                pe_q <= par_bad;
`endif
                                if (wr.full) begin
                                    ov_q <= 1'b1;
                                end else begin
                                    dout_q  <= sh;
                                    wr_en_q <= 1'b1;
                                end
                            end
                        end else begin
                            stop_bad <= ~vote;
                        end
                    end
                    if (at_wrap) begin
                        stop_idx <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr.wr_clk = clk_rx;
    assign wr.wr_en  = wr_en_q;
    assign wr.dout   = dout_q;
    assign frame_err = fe_q;
    assign overrun   = ov_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = pe_q;
`else
    assign parity_err = 1'b0;
`endif
endmodule
